// File: rtl/gmii_pkg.sv
// gmii_pkg: GMII framing constants and TX state encoding shared by the TX framer and RX checker
package gmii_pkg;
  localparam logic [7:0]  GMII_PREAMBLE  = 8'h55;
  localparam logic [7:0]  GMII_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REF = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} tx_state_t;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: one-byte step of the reflected Ethernet CRC-32, LSB of the byte first
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  always_comb begin
    o_crc = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) o_crc = (o_crc >> 1) ^ (o_crc[0] ? CRC32_POLY_REF : 32'h0);
  end
endmodule

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: wraps a valid/ready byte stream into a padded, FCS-terminated GMII frame
// Outputs are registered from the current state, so TXD trails the state by one cycle.
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic        i_tclk,
  input  logic        i_arstn,
  input  logic [7:0]  i_s_data,
  input  logic        i_s_valid,
  input  logic        i_s_last,
  output logic        o_s_ready,
  output logic [7:0]  o_txd,
  output logic        o_txen,
  output logic        o_txer,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_underrun_cnt
);
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME);
  localparam logic [10:0] IFG_LEN = 11'(IFG_BYTES);
  tx_state_t   r_state, w_state;
  logic [1:0]  r_sync;
  logic [10:0] r_cnt, w_cnt, w_cnt_inc;
  logic [31:0] r_crc, w_crc, w_crc_upd;
  logic [7:0]  w_txd, w_crc_byte;
  logic        w_txen, w_txer, w_frame_inc;
  crc32_d8 u_crc (.i_crc(r_crc), .i_data(w_crc_byte), .o_crc(w_crc_upd));
  assign w_crc_byte = (r_state == PAD) ? 8'h00 : i_s_data;
  assign w_cnt_inc  = &r_cnt ? r_cnt : r_cnt + 11'd1;
  assign o_s_ready  = r_state == DATA;
  assign o_busy     = r_state != IDLE;
  always_ff @(posedge i_tclk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_sync         <= 2'b00;
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_crc          <= CRC32_INIT;
      o_txd          <= 8'h00;
      o_txen         <= 1'b0;
      o_txer         <= 1'b0;
      o_frame_cnt    <= '0;
      o_underrun_cnt <= '0;
    end else begin
      r_sync  <= {r_sync[0], 1'b1};
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_crc   <= w_crc;
      o_txd   <= w_txd;
      o_txen  <= w_txen;
      o_txer  <= w_txer;
      if (w_frame_inc) o_frame_cnt <= o_frame_cnt + 16'd1;
      // counted as the error byte leaves, i.e. alongside the first TXEN-low cycle
      if (o_txer) o_underrun_cnt <= o_underrun_cnt + 16'd1;
    end
  end
  always_comb begin
    w_state     = r_state;
    w_cnt       = w_cnt_inc;
    w_crc       = r_crc;
    w_txd       = 8'h00;
    w_txen      = 1'b1;
    w_txer      = 1'b0;
    w_frame_inc = 1'b0;
    case (r_state)
      IDLE: begin
        w_txen  = i_s_valid && r_sync[1];
        w_txd   = w_txen ? GMII_PREAMBLE : 8'h00;
        w_state = w_txen ? PREAMBLE : IDLE;
        w_cnt   = '0;
        w_crc   = CRC32_INIT;
      end
      PREAMBLE: begin
        w_txd   = GMII_PREAMBLE;
        w_state = (r_cnt == 11'd5) ? SFD : PREAMBLE;
      end
      SFD: begin
        w_txd   = GMII_SFD;
        w_state = DATA;
        w_cnt   = '0;
      end
      DATA: begin
        w_txer = !i_s_valid;
        w_txd  = i_s_valid ? i_s_data : 8'h00;
        w_crc  = i_s_valid ? w_crc_upd : r_crc;
        if (!i_s_valid) begin
          w_state = IFG;
          w_cnt   = '0;
        end else if (i_s_last) begin
          w_state = (w_cnt_inc < MIN_LEN) ? PAD : FCS;
          w_cnt   = (w_cnt_inc < MIN_LEN) ? w_cnt_inc : '0;
        end
      end
      PAD: begin
        w_crc   = w_crc_upd;
        w_state = (w_cnt_inc == MIN_LEN) ? FCS : PAD;
        w_cnt   = (w_cnt_inc == MIN_LEN) ? '0 : w_cnt_inc;
      end
      FCS: begin
        w_txd       = ~r_crc[7:0];
        w_crc       = {8'h00, r_crc[31:8]};
        w_frame_inc = r_cnt == 11'd3;
        w_state     = w_frame_inc ? IFG : FCS;
        w_cnt       = w_frame_inc ? '0 : w_cnt_inc;
      end
      IFG: begin
        w_txen  = 1'b0;
        w_state = (r_cnt == IFG_LEN) ? IDLE : IFG;
      end
      default: begin
        w_txen  = 1'b0;
        w_state = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: directed checks of framing, padding, FCS, IFG, underrun and reset
module tb_gmii_tx_framer;
  logic clk = 0, arstn = 0, sel = 0, valid = 0, last = 0;
  logic [7:0] data = 0;
  logic r1, r0, en1, en0, er1, er0, b1, b0;
  logic [7:0] d1, d0;
  logic [15:0] fc1, fc0, uc1, uc0;
  logic ready_m, txen_m, txer_m, busy_m;
  logic [7:0] txd_m;
  int errors = 0, checks = 0;
  logic [7:0] pl[$], ex[$], cur[$], frm[$];
  int nfr = 0, lowrun = 0, gap = -1, ernum = 0;
  logic ptxen = 0;

  always #4 clk = ~clk;

  gmii_tx_framer #(.MIN_FRAME(60), .IFG_BYTES(12)) dut (
    .i_tclk(clk), .i_arstn(arstn), .i_s_data(data), .i_s_valid(valid && !sel), .i_s_last(last),
    .o_s_ready(r1), .o_txd(d1), .o_txen(en1), .o_txer(er1), .o_busy(b1),
    .o_frame_cnt(fc1), .o_underrun_cnt(uc1));
  gmii_tx_framer #(.MIN_FRAME(0), .IFG_BYTES(12)) dut0 (
    .i_tclk(clk), .i_arstn(arstn), .i_s_data(data), .i_s_valid(valid && sel), .i_s_last(last),
    .o_s_ready(r0), .o_txd(d0), .o_txen(en0), .o_txer(er0), .o_busy(b0),
    .o_frame_cnt(fc0), .o_underrun_cnt(uc0));

  assign ready_m = sel ? r0 : r1;
  assign txen_m  = sel ? en0 : en1;
  assign txer_m  = sel ? er0 : er1;
  assign txd_m   = sel ? d0 : d1;
  assign busy_m  = sel ? b0 : b1;

  always @(negedge clk) begin
    if (txen_m) begin
      if (!ptxen) gap = lowrun;
      cur.push_back(txd_m);
      if (txer_m) ernum++;
      lowrun = 0;
    end else begin
      lowrun++;
      if (ptxen) begin
        frm = cur;
        cur = {};
        nfr++;
      end
    end
    ptxen = txen_m;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int j = 0; j < 8; j++) begin
      fb = c[0] ^ b[j];
      c = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic build(input int minf);
    logic [31:0] c = 32'hFFFFFFFF;
    logic [7:0] b;
    int n;
    ex = {};
    for (int i = 0; i < 7; i++) ex.push_back(8'h55);
    ex.push_back(8'hD5);
    n = (pl.size() > minf) ? pl.size() : minf;
    for (int i = 0; i < n; i++) begin
      b = (i < pl.size()) ? pl[i] : 8'h00;
      ex.push_back(b);
      c = crc_step(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) ex.push_back(c[8*i +: 8]);
  endtask

  task automatic frame_chk(input string tag, input int minf);
    int bad = 0;
    build(minf);
    for (int i = 0; i < frm.size() && i < ex.size(); i++) if (frm[i] !== ex[i]) bad++;
    chk({tag, "_len"}, frm.size(), ex.size());
    chk({tag, "_bytes_bad"}, bad, 0);
  endtask

  task automatic send(input int n, input int stop_at, input bit hold);
    int i = 0, t = 0;
    bit hs;
    valid = 1; data = pl[0]; last = (n == 1);
    while (i < n && i != stop_at && t < 5000) begin
      @(negedge clk); hs = ready_m;
      @(posedge clk); #1; t++;
      if (hs) begin
        i++;
        if (i < n) begin data = pl[i]; last = (i == n - 1); end
      end
    end
    last = 0;
    if (!hold || i == stop_at) valid = 0;
    if (t >= 5000) chk("send_timeout", t, 0);
  endtask

  task automatic wait_nfr(input int target);
    int t = 0;
    while (nfr < target && t < 5000) begin @(negedge clk); t++; end
    #1;
    if (nfr < target) chk("frame_timeout", nfr, target);
  endtask

  initial begin
    int nb;
    #20;
    chk("rst_txd", txd_m, 0);
    chk("rst_txen", txen_m, 0);
    chk("rst_txer", txer_m, 0);
    chk("rst_ready", ready_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_fc", fc1, 0);
    chk("rst_uc", uc1, 0);
    @(posedge clk); #2 arstn = 1;
    repeat (3) @(posedge clk);
    #1;

    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    nb = nfr; ernum = 0;
    send(10, 3, 0);
    wait_nfr(nb + 1);
    chk("ur_len", frm.size(), 12);
    chk("ur_errbyte", frm[11], 8'h00);
    chk("ur_txer_cycles", ernum, 1);
    repeat (13) @(negedge clk);
    #1;
    chk("ur_low_run", lowrun >= 12, 1);
    chk("ur_cnt", uc1, 1);
    chk("ur_fc", fc1, 0);

    pl = '{8'h12, 8'h34, 8'h56, 8'h78};
    nb = nfr; ernum = 0;
    send(4, -1, 0);
    wait_nfr(nb + 1);
    frame_chk("padA", 60);
    chk("padA_fcs", {frm[71], frm[70], frm[69], frm[68]}, {ex[71], ex[70], ex[69], ex[68]});
    chk("padA_fc", fc1, 1);
    chk("padA_txer", ernum, 0);

    nb = nfr;
    send(4, -1, 1);
    send(4, -1, 0);
    wait_nfr(nb + 2);
    chk("b2b_gap", gap, 13);
    frame_chk("b2b_second", 60);
    chk("b2b_fc", fc1, 3);

    repeat (20) @(posedge clk);
    #1 sel = 1;
    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    nb = nfr;
    send(9, -1, 0);
    wait_nfr(nb + 1);
    frame_chk("min0", 0);
    chk("min0_fcs", {frm[20], frm[19], frm[18], frm[17]}, 32'hCBF43926);
    chk("min0_fc", fc0, 1);
    repeat (20) @(posedge clk);
    #1 sel = 0;

    pl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
    valid = 1; data = pl[0];
    for (int t = 0; t < 100 && !ready_m; t++) @(negedge clk);
    chk("rst_mid_in_data", ready_m, 1);
    @(posedge clk); @(posedge clk); #2;
    chk("rst_mid_txen_pre", txen_m, 1);
    arstn = 0; valid = 0;
    #1;
    chk("rst_mid_txen", txen_m, 0);
    chk("rst_mid_txer", txer_m, 0);
    chk("rst_mid_ready", ready_m, 0);
    chk("rst_mid_fc", fc1, 0);
    @(posedge clk); #2 arstn = 1;
    @(negedge clk); #1;
    pl = '{8'h12, 8'h34, 8'h56, 8'h78};
    nb = nfr;
    send(4, -1, 0);
    wait_nfr(nb + 1);
    frame_chk("post_rst", 60);
    chk("post_rst_fc", fc1, 1);

    repeat (20) @(posedge clk);
    #1 force dut.o_frame_cnt = 16'hFFFF;
    @(posedge clk); #1 release dut.o_frame_cnt;
    #1 chk("preset_fc", fc1, 16'hFFFF);
    pl = {};
    for (int i = 0; i < 1514; i++) pl.push_back(8'(i * 7 + 3));
    nb = nfr;
    send(1514, -1, 0);
    wait_nfr(nb + 1);
    frame_chk("big", 60);
    chk("big_fcs", {frm[1525], frm[1524], frm[1523], frm[1522]}, {ex[1525], ex[1524], ex[1523], ex[1522]});
    chk("big_fc_wrap", fc1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
